// File: rtl/sap_ctrl_pkg.sv
// Shared types and constants for the SAP control sequencer slice.
// The opcode and state encodings are declared here so the top module and the bench use the same values.
package sap_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 4;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LDA    = 3'd1,
        OP_LDB    = 3'd2,
        OP_ADD    = 3'd3,
        OP_SUB    = 3'd4,
        OP_OUT    = 3'd5,
        OP_REPADD = 3'd6,
        OP_RSVD   = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WRITE,
        S_EXEC,
        S_FLAG,
        S_OUTP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic nla;
        logic nlb;
        logic ea;
        logic eu;
        logic sub;
        logic out_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{nla: 1'b1, nlb: 1'b1, ea: 1'b0, eu: 1'b0, sub: 1'b0, out_sel: 1'b0};

endpackage

// File: rtl/sap_rep_counter.sv
// Repeat counter for REPADD.
// It loads the count, decrements it, and reports when the count is zero or on its final pass.
module sap_rep_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);
    assign last = (count == ONE);

endmodule

// File: rtl/sap_control_sequencer.sv
// Control sequencer for the adder/accumulator datapath. It accepts one macro-op per start handshake,
// steps the datapath through T-states and returns the flags. Every output is decoded from registered state only.
module sap_control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        opcode_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic              cf_i,
    input  logic              zf_i,
    output logic [DATA_W-1:0] data_o,
    output logic              nla_o,
    output logic              nlb_o,
    output logic              ea_o,
    output logic              eu_o,
    output logic              sub_o,
    output logic              out_sel_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cf_o,
    output logic              zf_o,
    output logic              ovf_o,
    output logic              err_o
);

    state_t            state, state_nxt;
    opcode_t           op_q;
    logic [DATA_W-1:0] operand_q;
    logic              accept, cnt_dec, cnt_zero, cnt_last;
    ctrl_t             ctrl;

    assign accept  = start_i && (state == S_IDLE);
    assign cnt_dec = (state == S_FLAG) && (op_q == OP_REPADD) && !cf_i && !cnt_zero;

    sap_rep_counter #(.CNT_W(CNT_W)) u_rep_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (cnt_dec),
        .load_val (operand_i[CNT_W-1:0]),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            operand_q <= '0;
            cf_o      <= 1'b0;
            zf_o      <= 1'b0;
            ovf_o     <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q      <= opcode_t'(opcode_i);
                operand_q <= operand_i;
                ovf_o     <= 1'b0;
                err_o     <= (opcode_t'(opcode_i) == OP_RSVD);
            end
            if (state == S_FLAG) begin
                cf_o <= cf_i;
                zf_o <= zf_i;
                if ((op_q == OP_REPADD) && cf_i) begin
                    ovf_o <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    unique case (opcode_t'(opcode_i))
                        OP_LDA, OP_LDB: state_nxt = S_DRIVE;
                        OP_ADD, OP_SUB: state_nxt = S_EXEC;
                        OP_OUT:         state_nxt = S_OUTP;
                        // A zero repeat count finishes directly, without any datapath writes.
                        OP_REPADD:      state_nxt = (operand_i[CNT_W-1:0] == '0) ? S_DONE : S_EXEC;
                        default:        state_nxt = S_DONE;
                    endcase
                end
            end
            S_DRIVE: state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_DONE;
            S_EXEC:  state_nxt = S_FLAG;
            S_FLAG:  state_nxt = ((op_q == OP_REPADD) && !cf_i && !cnt_last) ? S_EXEC : S_DONE;
            S_OUTP:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl   = CTRL_IDLE;
        data_o = '0;
        unique case (state)
            S_DRIVE: data_o = operand_q;
            S_WRITE: begin
                data_o = operand_q;
                if (op_q == OP_LDA) ctrl.nla = 1'b0;
                else                ctrl.nlb = 1'b0;
            end
            S_EXEC: begin
                ctrl.eu  = 1'b1;
                ctrl.sub = (op_q == OP_SUB);
                ctrl.nla = 1'b0;
            end
            S_OUTP: begin
                ctrl.ea      = 1'b1;
                ctrl.out_sel = 1'b1;
            end
            default: ;
        endcase
    end

    assign nla_o     = ctrl.nla;
    assign nlb_o     = ctrl.nlb;
    assign ea_o      = ctrl.ea;
    assign eu_o      = ctrl.eu;
    assign sub_o     = ctrl.sub;
    assign out_sel_o = ctrl.out_sel;
    assign busy_o    = (state != S_IDLE);
    assign done_o    = (state == S_DONE);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer. Each issued op pushes its expected completion into a queue,
// and a monitor pops that entry and checks it when done_o is seen.
module tb_sap_control_sequencer;
    import sap_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [2:0] opcode_i;
    logic [7:0] operand_i;
    logic       cf_i, zf_i;
    logic [7:0] data_o;
    logic       nla_o, nlb_o, ea_o, eu_o, sub_o, out_sel_o;
    logic       busy_o, done_o, cf_o, zf_o, ovf_o, err_o;

    typedef struct {
        string       name;
        int unsigned done_cyc;
        int unsigned execs;
        logic        cf, zf, ovf, err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned eu_cnt   = 0;
    logic [15:0] word;
    logic [3:0]  status;

    sap_control_sequencer #(.DATA_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i), .operand_i(operand_i),
        .cf_i(cf_i), .zf_i(zf_i), .data_o(data_o), .nla_o(nla_o), .nlb_o(nlb_o),
        .ea_o(ea_o), .eu_o(eu_o), .sub_o(sub_o), .out_sel_o(out_sel_o), .busy_o(busy_o),
        .done_o(done_o), .cf_o(cf_o), .zf_o(zf_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign word   = {data_o, nla_o, nlb_o, ea_o, eu_o, sub_o, out_sel_o, busy_o, done_o};
    assign status = {cf_o, zf_o, ovf_o, err_o};

    function automatic logic [15:0] mk(input logic [7:0] d, input logic nla, nlb, ea, eu, sub, sel, busy, done);
        return {d, nla, nlb, ea, eu, sub, sel, busy, done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] opnd, input string name,
                         input int unsigned lat, input int unsigned execs,
                         input logic cf, zf, ovf, err, input bit push, input bit hold);
        exp_t e;
        start_i   = 1'b1;
        opcode_i  = op;
        operand_i = opnd;
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
        if (push) begin
            e.name     = name;
            e.done_cyc = cyc + lat - 1;
            e.execs    = execs;
            e.cf       = cf;
            e.zf       = zf;
            e.ovf      = ovf;
            e.err      = err;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            eu_cnt = 0;
        end else begin
            if (eu_o) eu_cnt++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected no pending op", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_done_cycle"}, cyc, mon_e.done_cyc);
                    chk({mon_e.name, "_exec_pulses"}, eu_cnt, mon_e.execs);
                    chk({mon_e.name, "_status"}, {28'd0, status}, {28'd0, mon_e.cf, mon_e.zf, mon_e.ovf, mon_e.err});
                    chk({mon_e.name, "_busy_at_done"}, {31'd0, busy_o}, 32'd1);
                end
                eu_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish before 200000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; opcode_i = '0; operand_i = '0; cf_i = 1'b0; zf_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_word", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 0, 0));
        chk("reset_status", {28'd0, status}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LDA 0x2A: data leads the nla strobe by one cycle
        issue(OP_LDA, 8'h2A, "lda", 3, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk); chk("lda_c1", word, mk(8'h2A, 1, 1, 0, 0, 0, 0, 1, 0));
        @(negedge clk); chk("lda_c2", word, mk(8'h2A, 0, 1, 0, 0, 0, 0, 1, 0));
        @(negedge clk); chk("lda_c3", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 1, 1));
        @(negedge clk); chk("lda_c4", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 0, 0));

        issue(OP_LDB, 8'h05, "ldb", 3, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk); chk("ldb_c2", word, mk(8'h05, 1, 0, 0, 0, 0, 0, 1, 0));
        repeat (2) @(negedge clk);

        cf_i = 1'b0; zf_i = 1'b0;
        issue(OP_ADD, 8'h00, "add", 3, 1, 0, 0, 0, 0, 1, 0);
        @(negedge clk); chk("add_exec", word, mk(8'h00, 0, 1, 0, 1, 0, 0, 1, 0));
        repeat (3) @(negedge clk);

        cf_i = 1'b1; zf_i = 1'b1;
        issue(OP_SUB, 8'h00, "sub", 3, 1, 1, 1, 0, 0, 1, 0);
        @(negedge clk); chk("sub_exec", word, mk(8'h00, 0, 1, 0, 1, 1, 0, 1, 0));
        @(negedge clk); chk("sub_flag", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 1, 0));
        @(negedge clk); cf_i = 1'b0; zf_i = 1'b0;
        @(negedge clk);

        issue(OP_OUT, 8'h00, "out", 2, 0, 1, 1, 0, 0, 1, 0);
        @(negedge clk); chk("out_c1", word, mk(8'h00, 1, 1, 1, 0, 0, 1, 1, 0));
        @(negedge clk);
        @(negedge clk); chk("out_idle", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 0, 0));
        chk("out_zf_hold", {31'd0, zf_o}, 32'd1);

        issue(OP_REPADD, 8'h03, "rep3", 7, 3, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk); chk("rep3_flag_word", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 1, 0));
        repeat (6) @(negedge clk);

        // Only operand[3:0] is the repeat count, so 0xF0 repeats zero times.
        issue(OP_REPADD, 8'hF0, "rep0", 1, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk); chk("rep0_c1", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 1, 1));
        @(negedge clk);

        // Raise the carry during the second FLAG cycle, which is cycle 4.
        issue(OP_REPADD, 8'h0F, "rep15_ovf", 5, 2, 1, 0, 1, 0, 1, 0);
        repeat (3) @(negedge clk);
        cf_i = 1'b1;
        @(negedge clk);
        @(negedge clk); cf_i = 1'b0;
        @(negedge clk); chk("ovf_hold", {31'd0, ovf_o}, 32'd1);

        issue(OP_RSVD, 8'h00, "rsvd", 1, 0, 1, 0, 0, 1, 1, 0);
        @(negedge clk); chk("rsvd_c1", {30'd0, ovf_o, err_o}, 32'd1);
        @(negedge clk);

        // start_i stays high for the whole op, with different opcode and operand values after accept.
        issue(OP_LDA, 8'h11, "lda_hold", 3, 0, 1, 0, 0, 0, 1, 1);
        opcode_i = OP_LDB; operand_i = 8'h77;
        @(negedge clk); chk("hold_c1", word, mk(8'h11, 1, 1, 0, 0, 0, 0, 1, 0));
        @(negedge clk); chk("hold_c2", word, mk(8'h11, 0, 1, 0, 0, 0, 0, 1, 0));
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); chk("hold_idle", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 0, 0));

        // Reset during REPADD aborts the op without a done pulse.
        cf_i = 1'b0;
        issue(OP_REPADD, 8'h0F, "rep_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rep_rst_exec_before", {31'd0, eu_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rep_rst_word", word, mk(8'h00, 1, 1, 0, 0, 0, 0, 0, 0));
        chk("rep_rst_status", {28'd0, status}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        issue(OP_NOP, 8'h00, "nop", 1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Control-side initiator for the adder/accumulator datapath. It generates the control word the datapath consumes: data byte, nLa, nLb, Ea, Eu, sub and bus/regA output select.
- Accepts one macro-op per start handshake and sequences the datapath through T-states.
- Samples the datapath CF/ZF flags and returns status.
- Replaces manual driving of the control pins by an external host.

Parameters:
DATA_W, 8, datapath/bus width
CNT_W, 4, repeat-count width for REPADD (taken from operand[CNT_W-1:0])

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  request; accepted only when busy_o=0
opcode_i  in  3  macro-op, sampled on accept
operand_i  in  DATA_W  immediate byte / repeat count, sampled on accept
cf_i  in  1  datapath carry flag
zf_i  in  1  datapath zero flag
data_o  out  DATA_W  byte to datapath input port
nla_o  out  1  load A, active low
nlb_o  out  1  load B, active low
ea_o  out  1  enable A onto bus
eu_o  out  1  enable ALU onto bus
sub_o  out  1  ALU subtract
out_sel_o  out  1  1 = output bus, 0 = output regA
busy_o  out  1  op in progress
done_o  out  1  one-cycle completion pulse
cf_o  out  1  registered carry of last ALU op
zf_o  out  1  registered zero of last ALU op
ovf_o  out  1  REPADD stopped on carry
err_o  out  1  last opcode was reserved

Behaviour:
- Reset (async, rst=1), idle control word:
  - nla_o=1, nlb_o=1; ea_o, eu_o, sub_o, out_sel_o=0; data_o=0.
  - busy_o, done_o, cf_o, zf_o, ovf_o, err_o = 0.
  - State=IDLE. Reset mid-op aborts the op; no done_o.
- All outputs are registered: driven from state/registers, with no comb path from inputs.
- Accept: start_i=1 in IDLE. On that edge, latch opcode/operand, set busy_o=1, and clear ovf_o and err_o. start_i while busy is ignored.
- Opcodes: 0 NOP, 1 LDA, 2 LDB, 3 ADD, 4 SUB, 5 OUT, 6 REPADD, 7 reserved.
- States: IDLE, DRIVE, WRITE, EXEC, FLAG, OUTP, DONE.
- Sequences (one cycle per state, counted from the accept edge):
  - NOP: DONE.
  - LDA/LDB: DRIVE (data_o=operand) -> WRITE (data_o=operand; nla_o=0 or nlb_o=0) -> DONE. Data leads the write strobe by one cycle because the datapath buffers its input one cycle.
  - ADD/SUB: EXEC (eu_o=1, sub_o = opcode==SUB, nla_o=0) -> FLAG (idle word; cf_i/zf_i captured into cf_o/zf_o at end of FLAG) -> DONE.
  - OUT: OUTP (ea_o=1, out_sel_o=1) -> DONE.
  - REPADD: load rem = operand[CNT_W-1:0].
    - If rem=0: go to DONE with no writes.
    - Otherwise loop EXEC(add) -> FLAG.
    - After each FLAG: if captured cf=1, set ovf_o=1 and go to DONE.
    - Else rem--; if rem!=0 return to EXEC, else go to DONE.
    - Max 2*(2^CNT_W-1)+1 cycles.
  - Reserved (7): set err_o=1 -> DONE.
- DONE: done_o=1 for exactly one cycle, idle control word, busy_o=0 from the next cycle, return to IDLE. A new start_i is accepted on the first IDLE cycle.
- Flags: cf_o/zf_o update only in FLAG; they hold across NOP/LD/OUT.
- Exclusivity: at most one of ea_o/eu_o=1 in any cycle. nla_o and nlb_o are never both low.
- Arithmetic: counter wraps are impossible by construction (decrement only when rem!=0).

Decomposition:
- Package sap_ctrl_pkg:
  - opcode enum (OP_NOP..OP_RSVD)
  - state enum
  - idle control-word constants
  - DATA_W/CNT_W defaults
- One sub-module: sap_rep_counter (load / decrement / zero flag, CNT_W wide).
- FSM and output registers stay in the top.

Test Plan:
- Reset then LDA 0x2A: start cycle 0 -> cycle 1 data_o=0x2A, nla_o=1; cycle 2 nla_o=0, data_o=0x2A; cycle 3 done_o=1; busy_o=0 at cycle 4.
- LDB 0x05, then ADD with model cf_i=0, zf_i=0 -> EXEC shows eu_o=1, sub_o=0, nla_o=0; after FLAG cf_o=0, zf_o=0; done 3 cycles after accept.
- SUB with model returning zf_i=1 (A=B=0x05) -> sub_o=1 in EXEC, zf_o=1 after FLAG; a following OUT shows ea_o=1, out_sel_o=1 for one cycle, and zf_o is still 1.
- REPADD operand=3, cf_i=0 -> exactly 3 EXEC pulses, done_o at cycle 7, ovf_o=0. REPADD operand=0 -> done_o at cycle 1, no eu_o.
- REPADD operand=15, cf_i raised during the 2nd FLAG -> 2 EXEC pulses, ovf_o=1, cf_o=1.
- Opcode 7 -> err_o=1, done_o next cycle.
- start_i held high while busy -> ignored.
- rst pulsed mid-REPADD -> all outputs at idle values in the same cycle, no done_o.
